// File: rtl/axis_packet_arb_pkg.sv
// Shared types and helpers for the packet-granular AXI-Stream arbiter.
package axis_packet_arb_pkg;

  // Arbiter FSM: IDLE picks a source, PASS forwards one whole packet.
  typedef enum logic {
    IDLE = 1'b0,
    PASS = 1'b1
  } state_t;

  // Width of a source index; never narrower than one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_priority_select.sv
// Round-robin priority picker: returns the first requesting index found
// scanning upward from rr_ptr and wrapping mod N. Purely combinational.
module rr_priority_select
  import axis_packet_arb_pkg::*;
#(
  parameter int N = 2,
  parameter int W = id_width(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] rr_ptr,
  output logic [W-1:0] winner,
  output logic         any_req
);

  localparam int SW = W + 1;

  logic [SW-1:0] idx_sum;
  logic [W-1:0]  idx;

  // Scan offsets from far to near so the nearest requester is assigned last.
  // rr_ptr < N and offset < N, so a single subtraction implements the wrap.
  always_comb begin
    winner  = '0;
    any_req = 1'b0;
    idx_sum = '0;
    idx     = '0;
    for (int i = N - 1; i >= 0; i--) begin
      idx_sum = {1'b0, rr_ptr} + SW'(i);
      if (idx_sum >= SW'(N)) begin
        idx_sum = idx_sum - SW'(N);
      end
      idx = idx_sum[W-1:0];
      if (req[idx]) begin
        winner  = idx;
        any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axis_packet_arbiter.sv
// Packet-granular round-robin AXI-Stream arbiter with one registered output
// stage. A grant is held from the first beat until the tlast beat is taken,
// so packets never interleave. Optional macro AXIS_PACKET_ARB_ID_EN adds the
// registered output axis_o_id carrying the originating source index.
//
// Handshake: a beat moves on any edge where tvalid and tready are both high
// on that interface; tvalid never depends on tready, and a presented output
// beat is held stable until accepted.
module axis_packet_arbiter
  import axis_packet_arb_pkg::*;
#(
  parameter int NUM_INPUTS     = 2,
  parameter int AXIS_BYTES     = 1,
  parameter int AXIS_USER_BITS = 1
) (
  input  logic                                 clk,
  input  logic                                 aresetn,
  input  logic [NUM_INPUTS-1:0]                axis_i_tvalid,
  output logic [NUM_INPUTS-1:0]                axis_i_tready,
  input  logic [NUM_INPUTS*8*AXIS_BYTES-1:0]   axis_i_tdata,
  input  logic [NUM_INPUTS*AXIS_USER_BITS-1:0] axis_i_tuser,
  input  logic [NUM_INPUTS-1:0]                axis_i_tlast,
  output logic                                 axis_o_tvalid,
  input  logic                                 axis_o_tready,
  output logic [8*AXIS_BYTES-1:0]              axis_o_tdata,
  output logic [AXIS_USER_BITS-1:0]            axis_o_tuser,
  output logic                                 axis_o_tlast,
`ifdef AXIS_PACKET_ARB_ID_EN
  output logic [id_width(NUM_INPUTS)-1:0]      axis_o_id,
`endif
  output state_t                               fsm_state
);

  localparam int DW = 8 * AXIS_BYTES;
  localparam int UW = AXIS_USER_BITS;
  localparam int IW = id_width(NUM_INPUTS);

  state_t          state;
  state_t          state_next;
  logic [IW-1:0]   grant;
  logic [IW-1:0]   grant_next;
  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   rr_ptr_next;
  logic [IW-1:0]   winner;
  logic            any_req;
  logic            out_space;
  logic            beat;
  logic [DW-1:0]   sel_data;
  logic [UW-1:0]   sel_user;
  logic            sel_last;

  assign fsm_state = state;
  assign out_space = !axis_o_tvalid || axis_o_tready;

  // Only the granted slice is ever looked at.
  assign sel_data = axis_i_tdata[grant*DW +: DW];
  assign sel_user = axis_i_tuser[grant*UW +: UW];
  assign sel_last = axis_i_tlast[grant];

  rr_priority_select #(
    .N (NUM_INPUTS),
    .W (IW)
  ) u_select (
    .req     (axis_i_tvalid),
    .rr_ptr  (rr_ptr),
    .winner  (winner),
    .any_req (any_req)
  );

  // Next-state, grant, round-robin pointer and input ready decode.
  always_comb begin
    state_next    = state;
    grant_next    = grant;
    rr_ptr_next   = rr_ptr;
    axis_i_tready = '0;
    beat          = 1'b0;
    unique case (state)
      IDLE: begin
        if (any_req) begin
          grant_next = winner;
          state_next = PASS;
        end
      end
      PASS: begin
        axis_i_tready[grant] = out_space;
        beat                 = axis_i_tvalid[grant] && out_space;
        if (beat && sel_last) begin
          rr_ptr_next = (grant == IW'(NUM_INPUTS - 1)) ? '0 : grant + 1'b1;
          state_next  = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM, grant and pointer registers; reset restarts arbitration at source 0.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state  <= IDLE;
      grant  <= '0;
      rr_ptr <= '0;
    end else begin
      state  <= state_next;
      grant  <= grant_next;
      rr_ptr <= rr_ptr_next;
    end
  end

  // Output register: load on a granted beat, drain when downstream takes it.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      axis_o_tvalid <= 1'b0;
      axis_o_tdata  <= '0;
      axis_o_tuser  <= '0;
      axis_o_tlast  <= 1'b0;
    end else if (beat) begin
      axis_o_tvalid <= 1'b1;
      axis_o_tdata  <= sel_data;
      axis_o_tuser  <= sel_user;
      axis_o_tlast  <= sel_last;
    end else if (axis_o_tready) begin
      axis_o_tvalid <= 1'b0;
    end
  end

`ifdef AXIS_PACKET_ARB_ID_EN
  // Source index travels with the data it describes.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      axis_o_id <= '0;
    end else if (beat) begin
      axis_o_id <= grant;
    end
  end
`endif

endmodule

// File: doc/axis_packet_arbiter.md
Name: axis_packet_arbiter

Overview:
- Packet-granular round-robin arbiter that merges NUM_INPUTS AXI-Stream sources, typically axis_packet_fifo outputs, onto one AXI-Stream master.
- A grant is held from the first beat of a packet until its tlast beat is accepted, so packets never interleave.
- The output is a single registered stage with full-throughput handshake.
- Sits between per-source packet FIFOs and a shared egress (MAC, DMA, serialiser).

Parameters:
- NUM_INPUTS, 2, number of slave streams (1 must also work; arbitration is then trivial).
- AXIS_BYTES, 1, tdata width in bytes.
- AXIS_USER_BITS, 1, tuser width.

Ports:
- clk  input  1  clock.
- aresetn  input  1  reset, asynchronous, active-low.
- axis_i_tvalid  input  NUM_INPUTS  per-source valid.
- axis_i_tready  output  NUM_INPUTS  per-source ready.
- axis_i_tdata  input  NUM_INPUTS*8*AXIS_BYTES  source k occupies slice k.
- axis_i_tuser  input  NUM_INPUTS*AXIS_USER_BITS  source k occupies slice k.
- axis_i_tlast  input  NUM_INPUTS  per-source last.
- axis_o_tvalid  output  1  registered.
- axis_o_tready  input  1.
- axis_o_tdata  output  8*AXIS_BYTES  registered.
- axis_o_tuser  output  AXIS_USER_BITS  registered.
- axis_o_tlast  output  1  registered.

Behaviour:
- Reset (async assert, deassert sampled on clk):
  - state=IDLE, grant=0, rr_ptr=0.
  - axis_o_tvalid=0, axis_o_tdata/tuser/tlast=0.
  - All axis_i_tready=0.
- State IDLE:
  - axis_i_tready all 0.
  - If any axis_i_tvalid is set, pick the first set bit scanning from rr_ptr upward, wrapping mod NUM_INPUTS.
  - Register it as grant and go to PASS next cycle.
  - If no tvalid, stay in IDLE.
- State PASS:
  - axis_i_tready[grant] = !axis_o_tvalid || axis_o_tready. All other tready bits are 0.
  - On a granted beat (tvalid&tready), the output register loads {tlast,tdata,tuser} from slice grant and axis_o_tvalid<=1.
  - Otherwise, if axis_o_tready, axis_o_tvalid<=0.
  - On an accepted beat with tlast=1: rr_ptr <= (grant+1) mod NUM_INPUTS, state <= IDLE.
- Latency:
  - First input tvalid to first axis_o_tvalid is 2 cycles (1 arbitration + 1 output register).
  - Within a packet, throughput is 1 beat/cycle.
  - There is one idle arbitration cycle between packets: a packet of L beats occupies the input for L+1 cycles minimum.
- Grant lock:
  - If the granted source drops tvalid mid-packet, the arbiter waits in PASS and does not switch.
  - Other sources are starved until tlast.
- Fairness: any source with tvalid held is granted within NUM_INPUTS packets.
- Backpressure:
  - While the output is held (axis_o_tvalid=1, axis_o_tready=0), the output register and all outputs are stable.
  - All input tready bits are 0 during the hold.
- Simultaneous events: an output drain and a new load in the same cycle keeps tvalid=1 with the new data.
- Single-beat packet (tlast on the first beat) is legal: PASS lasts 1 cycle, then IDLE.
- rr_ptr wrap: from NUM_INPUTS-1 it wraps to 0. Non-power-of-2 NUM_INPUTS is supported.
- Reset mid-packet: the output packet is truncated with no tlast; downstream handles this. The arbiter restarts from source 0.
- Input tdata/tuser/tlast of ungranted sources are ignored.

Optional Feature:
- Macro: AXIS_PACKET_ARB_ID_EN.
- Defined:
  - Adds output port axis_o_id, width max(1,$clog2(NUM_INPUTS)), carrying grant.
  - axis_o_id is registered together with tdata, reset 0, stable under backpressure.
  - It is valid whenever axis_o_tvalid=1.
- Undefined:
  - The port is absent and no id register is built.
  - Behaviour is otherwise identical.

Decomposition:
- Package axis_packet_arb_pkg holds:
  - State enum {IDLE, PASS}.
  - Function id_width(n) returning max(1,$clog2(n)).
- Sub-module rr_priority_select:
  - Purely combinational.
  - Inputs: request vector and rr_ptr. Outputs: winner index and any_req.
  - Instantiated once.

Test Plan:
- Reset/idle: assert aresetn=0 mid-run with all tvalid=1 → all outputs and tready=0 immediately. After release, first grant is source 0.
- Round-robin, NUM_INPUTS=3, all sources continuously valid with 2-beat packets:
  - Output packet source order is 0,1,2,0,1,2.
  - Each packet is preceded by exactly 1 idle cycle.
  - First axis_o_tvalid appears 2 cycles after the first tvalid.
- Grant lock: source 1 sends beat 0, drops tvalid for 5 cycles, then sends tlast while source 0 is valid throughout → source 1's packet is contiguous on the output, and source 0's packet follows.
- Backpressure: axis_o_tready=0 for 4 cycles mid-packet → output data stable, axis_i_tready[grant]=0, no beat lost or duplicated (scoreboard compare).
- Single-beat and wrap: NUM_INPUTS=3, source 2 sends a 1-beat packet, then source 0 and source 2 both request → source 0 is granted next (rr_ptr wrapped to 0).
- With AXIS_PACKET_ARB_ID_EN: random traffic from 4 sources → axis_o_id matches the originating source on every beat, checked against the scoreboard.
